// File: rtl/composer_pkg.sv
// Shared definitions for the frequency-meter slice.
//   fm_state_e       : measurement FSM states (IDLE, MEASURE, DONE)
//   DEF_GATE_CYCLES  : default gate window, 1 s at 50 MHz
//   DEF_CNT_W        : default edge-counter / result width
package composer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } fm_state_e;

  localparam int DEF_GATE_CYCLES = 50000000;
  localparam int DEF_CNT_W       = 26;

endpackage

// File: rtl/freq_meter_if.sv
// Control/result bundle of freq_meter.
//   start    : one-cycle request to begin a measurement (master -> meter)
//   busy     : gate window open
//   freq     : rising-edge count of the last completed window
//   valid    : one-cycle pulse when freq/overflow update
//   overflow : last window saturated the edge counter
interface freq_meter_if
  import composer_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             start;
  logic             busy;
  logic [CNT_W-1:0] freq;
  logic             valid;
  logic             overflow;

  modport master (output start, input  busy, freq, valid, overflow);
  modport slave  (input  start, output busy, freq, valid, overflow);

endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// edge_pulse is a one-cycle pulse three CLOCK_50 edges after async_in rises.
//   CLOCK_50   : sampling clock
//   resetn     : asynchronous active-low reset, clears all flops
//   async_in   : asynchronous input
//   edge_pulse : synchronous rising-edge pulse
module sync_edge_detect (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic async_in,
  output logic edge_pulse
);

  logic sync1, sync2, sync2_d;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync2_d    <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync1      <= async_in;
      sync2      <= sync1;
      sync2_d    <= sync2;
      edge_pulse <= sync2 & ~sync2_d;
    end
  end

endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: counts rising edges of sig_in over a window of
// GATE_CYCLES CLOCK_50 cycles and reports the count when the window closes.
//   CLOCK_50 : system clock, rising edge
//   resetn   : asynchronous active-low reset (release is expected to be
//              synchronous to CLOCK_50, so no local reset synchronizer)
//   sig_in   : asynchronous signal under measurement
//   bus      : start / busy / freq / valid / overflow (slave side)
// GATE_CYCLES must be at least 4.
module freq_meter
  import composer_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic         CLOCK_50,
  input  logic         resetn,
  input  logic         sig_in,
  freq_meter_if.slave  bus
);

  localparam int               GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  fm_state_e        state;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             sat;
  logic             edge_pulse;

  logic [CNT_W-1:0] edge_nxt;
  logic             sat_nxt;

  sync_edge_detect u_sync (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .async_in   (sig_in),
    .edge_pulse (edge_pulse)
  );

  // Saturating edge count including this cycle's pulse, so an edge in the
  // last gate cycle reaches the reported result. The flag marks a discarded
  // edge: a count pinned at max with overflow=0 is exact.
  always_comb begin
    edge_nxt = edge_cnt;
    sat_nxt  = sat;
    if (edge_pulse) begin
      if (edge_cnt == CNT_MAX) sat_nxt  = 1'b1;
      else                     edge_nxt = edge_cnt + CNT_W'(1);
    end
  end

  // busy/valid are registered with the state transition so they line up
  // exactly with MEASURE/DONE.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      gate_cnt     <= '0;
      edge_cnt     <= '0;
      sat          <= 1'b0;
      bus.busy     <= 1'b0;
      bus.valid    <= 1'b0;
      bus.freq     <= '0;
      bus.overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.valid <= 1'b0;
          if (bus.start) begin
            state    <= MEASURE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            bus.busy <= 1'b1;
          end
        end
        MEASURE: begin
          gate_cnt <= gate_cnt + GW'(1);
          edge_cnt <= edge_nxt;
          sat      <= sat_nxt;
          if (gate_cnt == GATE_LAST) begin
            state        <= DONE;
            bus.busy     <= 1'b0;
            bus.valid    <= 1'b1;
            bus.freq     <= edge_nxt;
            bus.overflow <= sat_nxt;
          end
        end
        DONE: begin
          bus.valid <= 1'b0;
          if (bus.start) begin
            state    <= MEASURE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            bus.busy <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          bus.busy  <= 1'b0;
          bus.valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two meters (CNT_W=26 and CNT_W=4) share sig_in and
// start. The expected count is the number of sig_in rising edges the bench
// itself generated across a 1000-cycle span aligned to the window.
module tb_freq_meter;

  localparam int GATE = 1000;

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;
  logic sig_in   = 1'b0;

  freq_meter_if #(.CNT_W(26)) bus_a ();
  freq_meter_if #(.CNT_W(4))  bus_b ();

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(26)) dut_a (
    .CLOCK_50 (CLOCK_50), .resetn (resetn), .sig_in (sig_in), .bus (bus_a.slave));
  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(4)) dut_b (
    .CLOCK_50 (CLOCK_50), .resetn (resetn), .sig_in (sig_in), .bus (bus_b.slave));

  always #10 CLOCK_50 = ~CLOCK_50;

  int tests = 0;
  int fails = 0;
  int half  = 0;   // sig_in half period in cycles, 0 = held low
  int ph    = 0;
  int tb_edges = 0;

  // Square-wave source, changes away from the sampling edge.
  always @(negedge CLOCK_50) begin
    if (half == 0) begin
      sig_in = 1'b0;
      ph     = 0;
    end else if (ph >= half - 1) begin
      ph = 0;
      if (!sig_in) tb_edges++;
      sig_in = ~sig_in;
    end else begin
      ph++;
    end
  end

  task automatic step();
    @(negedge CLOCK_50);
    #1;
  endtask

  task automatic set_start(input logic v);
    bus_a.start = v;
    bus_b.start = v;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input logic [63:0] obs, input int lo, input int hi);
    tests++;
    assert ((obs >= 64'(lo)) && (obs <= 64'(hi))) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Reference: true count d known to +-1; the 4-bit meter clips at 15 and
  // flags overflow only when the true count certainly exceeds 15.
  task automatic chk_result(input string tag, input int d);
    int lo, hi;
    lo = (d > 0) ? d - 1 : 0;
    hi = d + 1;
    chk_rng({tag, "_freq_a"}, 64'(bus_a.freq), lo, hi);
    chk({tag, "_ovf_a"}, 64'(bus_a.overflow), 64'd0);
    chk_rng({tag, "_freq_b"}, 64'(bus_b.freq), (lo > 15) ? 15 : lo, (hi > 15) ? 15 : hi);
    if (lo > 15)       chk({tag, "_ovf_b"}, 64'(bus_b.overflow), 64'd1);
    else if (hi <= 15) chk({tag, "_ovf_b"}, 64'(bus_b.overflow), 64'd0);
  endtask

  // One start pulse, optional re-pulse of start at busy cycle restart_at.
  task automatic window(input int restart_at, input string tag);
    int e0, e1, bc, vc, g;
    step();
    set_start(1'b1);
    e0 = tb_edges;
    step();
    set_start(1'b0);
    bc = 0; vc = 0; g = 0; e1 = e0;
    while (vc == 0 && g < 3000) begin
      if (bus_a.busy) begin
        bc++;
        if (bc == GATE) e1 = tb_edges;
      end
      if (bus_a.valid) vc++;
      set_start(bc == restart_at);
      step();
      g++;
    end
    set_start(1'b0);
    chk({tag, "_busy_len"}, 64'(bc), 64'(GATE));
    chk({tag, "_valid_seen"}, 64'(vc), 64'd1);
    chk({tag, "_valid_1cyc"}, 64'(bus_a.valid), 64'd0);
    chk({tag, "_b_busy"}, 64'(bus_b.busy), 64'd0);
    chk_result(tag, e1 - e0);
  endtask

  initial begin
    int g, nv, t1, t2, bc, extra;
    set_start(1'b0);

    // Reset state
    #1;
    chk("rst_busy",  64'(bus_a.busy),     64'd0);
    chk("rst_valid", 64'(bus_a.valid),    64'd0);
    chk("rst_freq",  64'(bus_a.freq),     64'd0);
    chk("rst_ovf",   64'(bus_a.overflow), 64'd0);
    chk("rst_freq_b", 64'(bus_b.freq),    64'd0);
    repeat (3) step();
    resetn = 1'b1;
    step();

    // 1 MHz: 20 edges; the 4-bit meter saturates
    half = 25;
    repeat (5) step();
    window(-1, "mhz1");
    chk("mhz1_freq_b_sat", 64'(bus_b.freq), 64'd15);

    // Silence
    half = 0;
    repeat (8) step();
    window(-1, "silent");
    chk("silent_freq_exact", 64'(bus_a.freq), 64'd0);

    // 5 MHz then 100 kHz
    half = 5;
    repeat (5) step();
    window(-1, "mhz5");
    chk("mhz5_ovf_b", 64'(bus_b.overflow), 64'd1);
    half = 250;
    ph   = 0;
    window(-1, "khz100");
    chk("khz100_ovf_b", 64'(bus_b.overflow), 64'd0);

    // start re-pulsed mid-window is ignored; no second valid follows
    half = 25;
    window(500, "ignstart");
    extra = 0;
    repeat (1100) begin
      if (bus_a.valid) extra++;
      step();
    end
    chk("ignstart_no_extra_valid", 64'(extra), 64'd0);

    // Back-to-back: start held through DONE
    step();
    set_start(1'b1);
    g = 0; nv = 0; t1 = 0; t2 = 0;
    while (nv < 2 && g < 4000) begin
      step();
      g++;
      if (bus_a.valid) begin
        nv++;
        if (nv == 1) t1 = g;
        else         t2 = g;
      end
    end
    set_start(1'b0);
    chk("b2b_valids", 64'(nv), 64'd2);
    chk("b2b_gap", 64'(t2 - t1), 64'(GATE + 1));
    chk_rng("b2b_freq", 64'(bus_a.freq), 19, 21);
    step();
    chk("b2b_idle_after", 64'(bus_a.busy), 64'd0);

    // Reset mid-window at gate cycle 300
    step();
    set_start(1'b1);
    step();
    set_start(1'b0);
    bc = 0; g = 0;
    while (g < 2000) begin
      if (bus_a.busy) bc++;
      if (bc == 300) break;
      step();
      g++;
    end
    chk("rstmid_reached", 64'(bc), 64'd300);
    resetn = 1'b0;
    #1;
    chk("rstmid_busy",  64'(bus_a.busy),     64'd0);
    chk("rstmid_freq",  64'(bus_a.freq),     64'd0);
    chk("rstmid_valid", 64'(bus_a.valid),    64'd0);
    chk("rstmid_ovf_b", 64'(bus_b.overflow), 64'd0);
    extra = 0;
    repeat (3) begin
      step();
      if (bus_a.valid) extra++;
    end
    resetn = 1'b1;
    repeat (3) begin
      step();
      if (bus_a.valid) extra++;
    end
    chk("rstmid_no_valid", 64'(extra), 64'd0);
    window(-1, "postrst");

    // Randomized rates
    repeat (5) begin
      half = $urandom_range(300, 3);
      ph   = 0;
      repeat (5) step();
      window(-1, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 50000000: gate window length in CLOCK_50 cycles (1 s).
REQ-002 SHALL have parameter CNT_W, default 26: width of the edge counter and the result.
REQ-003 SHALL have port CLOCK_50, input, 1 bit: the single system clock; all logic runs on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port sig_in, input, 1 bit: signal under measurement, asynchronous to CLOCK_50.
REQ-006 SHALL have port start, input, 1 bit: one-cycle request to begin a measurement.
REQ-007 SHALL have port busy, output, 1 bit: high while a gate window is open.
REQ-008 SHALL have port freq, output, CNT_W bits: rising-edge count of the last completed window.
REQ-009 SHALL have port valid, output, 1 bit: one-cycle pulse when freq updates.
REQ-010 SHALL have port overflow, output, 1 bit: set when the last window saturated the counter.

Function
REQ-011 SHALL pass sig_in through a 2-flop synchronizer, then a registered rising-edge detector, giving a one-cycle edge pulse 3 cycles after the sig_in transition.
REQ-012 SHALL implement a state machine with states IDLE, MEASURE and DONE.
REQ-013 IDLE: start=1 SHALL move the FSM to MEASURE on the next cycle, clearing the gate counter and the edge counter.
REQ-014 MEASURE: busy=1, and the gate counter SHALL increment once per cycle starting from 0.
REQ-015 MEASURE: each edge pulse SHALL increment the edge counter by 1.
REQ-016 An edge pulse in the cycle where the gate counter equals GATE_CYCLES-1 SHALL be counted; that is the final cycle of MEASURE.
REQ-017 After the final MEASURE cycle, the FSM SHALL enter DONE, where freq <= edge counter, overflow <= saturation flag and valid=1 for exactly that cycle.
REQ-018 DONE SHALL return to IDLE on the next cycle unless start=1, in which case it SHALL go directly to MEASURE (back-to-back measurement).
REQ-019 start asserted during MEASURE SHALL be ignored; the window SHALL NOT restart.
REQ-020 The edge counter SHALL saturate at 2^CNT_W-1 and set an internal saturation flag; further edges are discarded.
REQ-021 freq and overflow SHALL hold their values between DONE cycles, including through IDLE and the following MEASURE.
REQ-022 Synchronizer latency SHALL NOT be compensated: edges in the final 3 cycles of a window may fall into no window; ±1 count accuracy is the requirement.
REQ-023 The edge counter SHALL be CNT_W bits and the gate counter $clog2(GATE_CYCLES) bits; gate compare SHALL be an equality test against GATE_CYCLES-1.
REQ-024 GATE_CYCLES SHALL be at least 4; smaller values are unsupported.

Reset
REQ-025 resetn=0 SHALL asynchronously force state=IDLE, busy=0, valid=0, freq=0 and overflow=0, and clear all counters and synchronizer flops.
REQ-026 Reset asserted mid-MEASURE SHALL abort the window without producing a valid pulse; freq SHALL read 0 afterwards.
REQ-027 Reset deassertion SHALL be synchronous to CLOCK_50, so the first start is accepted no earlier than the first rising edge after release.

Structure
REQ-028 The FSM state enumeration (IDLE, MEASURE, DONE) and the default GATE_CYCLES/CNT_W constants SHALL live in shared package composer_pkg.
REQ-029 Synchronizer plus edge detector SHALL be a sub-module named sync_edge_detect, reusable by other asynchronous-input blocks.
REQ-030 freq_meter SHALL contain only the FSM, the counters and the output registers.

Verification
REQ-031 Measurement: GATE_CYCLES=1000, sig_in 1 MHz square wave, start pulse -> busy high 1000 cycles, then valid pulse with freq=20 (±1), overflow=0.
REQ-032 Silence: sig_in held 0, start pulse -> valid after 1000 cycles, freq=0.
REQ-033 Saturation: CNT_W=4, GATE_CYCLES=1000, sig_in 5 MHz -> freq=15, overflow=1; a following window at 100 kHz -> freq=2 (±1), overflow=0.
REQ-034 Ignored start: start re-pulsed at gate cycle 500 -> window length stays 1000 cycles, exactly one valid pulse.
REQ-035 Back-to-back: start held high through DONE -> MEASURE re-entered with no IDLE cycle; two consecutive valid pulses 1001 cycles apart.
REQ-036 Reset mid-window: resetn pulled low at gate cycle 300 -> busy=0 and freq=0 immediately, no valid pulse; next start measures normally.
